// File: rtl/alu_pkg.sv
// Shared definitions for the 6502 datapath ALU: operation encodings,
// status-flag bit positions and a helper that packs the flag nibble.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SR  = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_op_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    // Place the individual flags at their fixed bit positions.
    function automatic logic [3:0] pack_flags(
        input logic negative,
        input logic overflow,
        input logic zero,
        input logic carry
    );
        logic [3:0] f;
        f         = 4'h0;
        f[FLAG_N] = negative;
        f[FLAG_V] = overflow;
        f[FLAG_Z] = zero;
        f[FLAG_C] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_adder8.sv
// 8-bit binary adder with carry in; reports unsigned carry out and
// two's-complement overflow of the sum.
module alu_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out,
    output logic       overflow
);

    logic [8:0] sum9;

    // A ninth bit holds the carry so the sum wraps modulo 256.
    assign sum9      = {1'b0, a} + {1'b0, b} + {8'h00, carry_in};
    assign sum       = sum9[7:0];
    assign carry_out = sum9[8];

    // Signed overflow: operands agree in sign but the result does not.
    assign overflow  = (a[7] == b[7]) && (sum9[7] != a[7]);

endmodule

// File: rtl/alu.sv
// 6502 datapath ALU: combinational result and flags for ADD, shift right
// through carry, AND, OR and XOR, plus a registered copy for sequencing.
module alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alu_control,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry_in,
    output logic [7:0] alu_Y,
    output logic       alu_carry_out,
    output logic       alu_overflow,
    output logic       alu_zero,
    output logic       alu_negative,
    output logic [7:0] alu_Y_q,
    output logic [3:0] alu_flags_q
);

    alu_op_t    op;
    logic [7:0] add_sum;
    logic       add_carry;
    logic       add_overflow;
    logic [7:0] y_mux;
    logic       c_mux;
    logic       v_mux;
    logic [3:0] flags_d;

    assign op = alu_op_t'(alu_control);

    alu_adder8 u_adder (
        .a         (alu_AI),
        .b         (alu_BI),
        .carry_in  (alu_carry_in),
        .sum       (add_sum),
        .carry_out (add_carry),
        .overflow  (add_overflow)
    );

    // Operation select; unused codes fall through to an AI pass-through.
    always_comb begin
        y_mux = alu_AI;
        c_mux = 1'b0;
        v_mux = 1'b0;
        case (op)
            ADD: begin
                y_mux = add_sum;
                c_mux = add_carry;
                v_mux = add_overflow;
            end
            SR: begin
                y_mux = {alu_carry_in, alu_AI[7:1]};
                c_mux = alu_AI[0];
            end
            AND: y_mux = alu_AI & alu_BI;
            OR:  y_mux = alu_AI | alu_BI;
            XOR: y_mux = alu_AI ^ alu_BI;
            default: y_mux = alu_AI;
        endcase
    end

    assign alu_Y         = y_mux;
    assign alu_carry_out = c_mux;
    assign alu_overflow  = v_mux;
    assign alu_zero      = (y_mux == 8'h00);
    assign alu_negative  = y_mux[7];

    assign flags_d = pack_flags(alu_negative, alu_overflow, alu_zero, alu_carry_out);

    // Capture result and flags every edge; reset clears only this copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_Y_q     <= 8'h00;
            alu_flags_q <= 4'h0;
        end else begin
            alu_Y_q     <= alu_Y;
            alu_flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: exhaustive combinational sweeps against an
// arithmetic reference model, literal spot values, registered-path checks.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_control;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry_in;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_negative;
    logic [7:0] alu_Y_q;
    logic [3:0] alu_flags_q;

    int cmp_count  = 0;
    int fail_count = 0;

    logic        reg_check_en = 1'b0;
    logic [11:0] exp_q;
    event        chk;

    alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_control   (alu_control),
        .alu_AI        (alu_AI),
        .alu_BI        (alu_BI),
        .alu_carry_in  (alu_carry_in),
        .alu_Y         (alu_Y),
        .alu_carry_out (alu_carry_out),
        .alu_overflow  (alu_overflow),
        .alu_zero      (alu_zero),
        .alu_negative  (alu_negative),
        .alu_Y_q       (alu_Y_q),
        .alu_flags_q   (alu_flags_q)
    );

    // Free-running clock, 20 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: returns {Y[7:0], N, V, Z, C} from arithmetic rules.
    function automatic logic [11:0] model_alu(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic ci);
        int         s;
        int         sa;
        int         sb;
        logic [7:0] y;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        y = a;
        case (op)
            3'd0: begin
                s  = int'(a) + int'(b) + int'(ci);
                y  = 8'(s % 256);
                c  = (s > 255);
                sa = (int'(a) > 127) ? int'(a) - 256 : int'(a);
                sb = (int'(b) > 127) ? int'(b) - 256 : int'(b);
                s  = sa + sb + int'(ci);
                v  = (s > 127) || (s < -128);
            end
            3'd1: begin
                y = 8'(int'(ci) * 128 + int'(a) / 2);
                c = ((int'(a) % 2) == 1);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            default: y = a;
        endcase
        return {y, (int'(y) >= 128), v, (int'(y) == 0), c};
    endfunction

    // Expected registered copy, tracked from the model at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 12'h000;
        else        exp_q <= model_alu(alu_control, alu_AI, alu_BI, alu_carry_in);
    end

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] expv);
        cmp_count++;
        if (act !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h (ctl=%0d AI=%02h BI=%02h ci=%0b)",
                     name, act, expv, alu_control, alu_AI, alu_BI, alu_carry_in);
        end
    endtask

    // Single compare process: combinational outputs every vector, registers when enabled.
    always @(chk) begin
        checkOutput("comb", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out},
                    model_alu(alu_control, alu_AI, alu_BI, alu_carry_in));
        if (reg_check_en)
            checkOutput("regs", {alu_Y_q, alu_flags_q}, exp_q);
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
        alu_control  = op;
        alu_AI       = a;
        alu_BI       = b;
        alu_carry_in = ci;
        #1;
        ->chk;
        #1;
    endtask

    task automatic regStep(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic ci);
        @(negedge clk);
        applyStimulus(op, a, b, ci);
    endtask

    initial begin
        rst_n        = 1'b0;
        alu_control  = 3'd0;
        alu_AI       = 8'h00;
        alu_BI       = 8'h00;
        alu_carry_in = 1'b0;
        #1;
        checkOutput("reset_state", {alu_Y_q, alu_flags_q}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Literal spot values pinning the model and the DUT.
        applyStimulus(3'd0, 8'hFF, 8'h01, 1'b0); checkOutput("add_ff_01", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h003);
        applyStimulus(3'd0, 8'h50, 8'h50, 1'b0); checkOutput("add_50_50", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'hA0C);
        applyStimulus(3'd0, 8'h80, 8'h80, 1'b0); checkOutput("add_80_80", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h007);
        applyStimulus(3'd0, 8'h7F, 8'h00, 1'b1); checkOutput("add_7f_00_c", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h80C);
        applyStimulus(3'd1, 8'h81, 8'h00, 1'b0); checkOutput("lsr_81", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h401);
        applyStimulus(3'd1, 8'h02, 8'hFF, 1'b1); checkOutput("ror_02", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h818);
        applyStimulus(3'd2, 8'hF0, 8'h3C, 1'b1); checkOutput("and_f0_3c", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h300);
        applyStimulus(3'd3, 8'hF0, 8'h3C, 1'b1); checkOutput("or_f0_3c", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'hFC8);
        applyStimulus(3'd4, 8'hF0, 8'h3C, 1'b0); checkOutput("xor_f0_3c", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'hCC8);
        applyStimulus(3'd7, 8'h5A, 8'hFF, 1'b1); checkOutput("unused_7", {alu_Y, alu_negative, alu_overflow, alu_zero, alu_carry_out}, 12'h5A0);

        // Exhaustive ADD at both carry-in values.
        for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 256; a++)
                for (int b = 0; b < 256; b++)
                    applyStimulus(3'd0, 8'(a), 8'(b), 1'(ci));

        // Shift right through carry, every AI at both carry-in values.
        for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 256; a++)
                applyStimulus(3'd1, 8'(a), 8'(255 - a), 1'(ci));

        // Exhaustive logic operations; carry-in toggled to show it is ignored.
        for (int op = 2; op < 5; op++)
            for (int a = 0; a < 256; a++)
                for (int b = 0; b < 256; b++)
                    applyStimulus(3'(op), 8'(a), 8'(b), 1'(b % 2));

        // Unused codes pass AI through.
        for (int op = 5; op < 8; op++)
            for (int a = 0; a < 256; a += 17)
                applyStimulus(3'(op), 8'(a), 8'(a ^ 8'hA5), 1'b1);

        // Registered path: one-cycle latency.
        regStep(3'd0, 8'h01, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reg_add_1_1", {alu_Y_q, alu_flags_q}, 12'h020);
        reg_check_en = 1'b1;
        regStep(3'd0, 8'h50, 8'h50, 1'b0);
        regStep(3'd0, 8'hFF, 8'h01, 1'b0);
        regStep(3'd1, 8'h02, 8'h00, 1'b1);
        regStep(3'd4, 8'hF0, 8'h3C, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reg_xor", {alu_Y_q, alu_flags_q}, 12'hCC8);

        // Asynchronous reset between edges clears registers only.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {alu_Y_q, alu_flags_q}, 12'h000);
        ->chk;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_hold", {alu_Y_q, alu_flags_q}, 12'h000);
        ->chk;
        @(posedge clk);
        #1;
        checkOutput("after_release", {alu_Y_q, alu_flags_q}, 12'hCC8);
        ->chk;
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
